// File: rtl/stage_pipe_reg.sv
// Parametrised pipeline-boundary register: NCH write-back channels carried across DEPTH
// stages, with hold / bubble / flush control decoded from the global stall vector.
module stage_pipe_reg #(
    parameter int STAGE   = 4,
    parameter int STALL_W = 6,
    parameter int NCH     = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [NCH-1:0]        in_we,
    input  logic [NCH*ADDR_W-1:0] in_addr,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    output logic [NCH-1:0]        out_we,
    output logic [NCH*ADDR_W-1:0] out_addr,
    output logic [NCH*DATA_W-1:0] out_data,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      hold_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef enum logic [1:0] {
        CTL_LOAD   = 2'd0,
        CTL_BUBBLE = 2'd1,
        CTL_HOLD   = 2'd2,
        CTL_FLUSH  = 2'd3
    } ctl_e;

    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [NCH-1:0]        WE_ZERO   = {NCH{1'b0}};
    localparam logic [NCH*ADDR_W-1:0] ADDR_ZERO = {(NCH*ADDR_W){1'b0}};
    localparam logic [NCH*DATA_W-1:0] DATA_ZERO = {(NCH*DATA_W){1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    ctl_e                  ctl_s;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [NCH-1:0]        we_q   [DEPTH];
    logic [NCH-1:0]        we_d   [DEPTH];
    logic [NCH*ADDR_W-1:0] addr_q [DEPTH];
    logic [NCH*ADDR_W-1:0] addr_d [DEPTH];
    logic [NCH*DATA_W-1:0] data_q [DEPTH];
    logic [NCH*DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic                  stall_unused_s;

    // Only two stall bits matter to this boundary; fold the rest away.
    assign stall_unused_s = ^stall;

    // Decode the boundary control in priority order (reset is applied in the datapath).
    always_comb begin
        ctl_s = CTL_LOAD;
        if (flush) begin
            ctl_s = CTL_FLUSH;
        end else if (stall[STAGE]) begin
            if (stall[STAGE+1]) begin
                ctl_s = CTL_HOLD;
            end else begin
                ctl_s = CTL_BUBBLE;
            end
        end else begin
            ctl_s = CTL_LOAD;
        end
    end

    // Next-state of every slot; HOLD falls through to the defaults.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (rst || (ctl_s == CTL_FLUSH)) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
                we_d[k]    = WE_ZERO;
                addr_d[k]  = ADDR_ZERO;
                data_d[k]  = DATA_ZERO;
            end
        end else begin
            case (ctl_s)
                CTL_LOAD, CTL_BUBBLE: begin
                    // A bubble is a fully zeroed slot, so address 0 doubles as the NOP register.
                    valid_d[0] = (ctl_s == CTL_LOAD) ? in_valid : 1'b0;
                    we_d[0]    = (ctl_s == CTL_LOAD) ? in_we    : WE_ZERO;
                    addr_d[0]  = (ctl_s == CTL_LOAD) ? in_addr  : ADDR_ZERO;
                    data_d[0]  = (ctl_s == CTL_LOAD) ? in_data  : DATA_ZERO;
                    for (int k = 1; k < DEPTH; k++) begin
                        valid_d[k] = valid_q[k-1];
                        we_d[k]    = we_q[k-1];
                        addr_d[k]  = addr_q[k-1];
                        data_d[k]  = data_q[k-1];
                    end
                end
                default: begin
                    valid_d = valid_q;
                end
            endcase
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (rst || cnt_clr) begin
            hold_cnt_d   = CNT_ZERO;
            bubble_cnt_d = CNT_ZERO;
        end else if (ctl_s == CTL_HOLD) begin
            hold_cnt_d = sat_inc(hold_cnt_q);
        end else if (ctl_s == CTL_BUBBLE) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        valid_q      <= valid_d;
        we_q         <= we_d;
        addr_q       <= addr_d;
        data_q       <= data_d;
        hold_cnt_q   <= hold_cnt_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign out_valid  = valid_q[DEPTH-1];
    assign out_we     = we_q[DEPTH-1];
    assign out_addr   = addr_q[DEPTH-1];
    assign out_data   = data_q[DEPTH-1];
    assign hold_cnt   = hold_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Randomised and directed bench for stage_pipe_reg: a DEPTH=1/CNT_W=4 instance and a
// DEPTH=3 instance share inputs and are checked against a queue-based slot model.
module tb_stage_pipe_reg;

    typedef struct packed {
        logic        v;
        logic [2:0]  we;
        logic [14:0] addr;
        logic [95:0] data;
    } slot_t;
    typedef slot_t slotq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_we = 3'd0;
    logic [14:0] in_addr = 15'd0;
    logic [95:0] in_data = 96'd0;
    logic        cnt_clr = 1'b0;

    logic        o1_valid, o3_valid;
    logic [2:0]  o1_we, o3_we;
    logic [14:0] o1_addr, o3_addr;
    logic [95:0] o1_data, o3_data;
    logic [3:0]  o1_hold, o1_bub;
    logic [15:0] o3_hold, o3_bub;
    slot_t       o1_s, o3_s;

    assign o1_s = {o1_valid, o1_we, o1_addr, o1_data};
    assign o3_s = {o3_valid, o3_we, o3_addr, o3_data};

    int checks = 0;
    int failures = 0;

    slotq_t m1, m3;
    int hc1 = 0, bc1 = 0, hc3 = 0, bc3 = 0;

    always #5 clk = ~clk;

    stage_pipe_reg #(.STAGE(4), .STALL_W(6), .NCH(3), .ADDR_W(5), .DATA_W(32),
                     .DEPTH(1), .CNT_W(4)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .out_valid(o1_valid),
        .out_we(o1_we), .out_addr(o1_addr), .out_data(o1_data), .cnt_clr(cnt_clr),
        .hold_cnt(o1_hold), .bubble_cnt(o1_bub));

    stage_pipe_reg #(.STAGE(4), .STALL_W(6), .NCH(3), .ADDR_W(5), .DATA_W(32),
                     .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .out_valid(o3_valid),
        .out_we(o3_we), .out_addr(o3_addr), .out_data(o3_data), .cnt_clr(cnt_clr),
        .hold_cnt(o3_hold), .bubble_cnt(o3_bub));

    function automatic slotq_t advance(slotq_t q, int depth, slot_t cur,
                                       bit clr, bit hold, bit bub);
        slotq_t r;
        slot_t  z;
        z = '0;
        r = q;
        if (clr) begin
            r = {};
            for (int i = 0; i < depth; i++) r.push_back(z);
        end else if (!hold) begin
            r.push_front(bub ? z : cur);
            void'(r.pop_back());
        end
        return r;
    endfunction

    function automatic int sat(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // One clock: the model applies the spec rules to the inputs present at the edge.
    task automatic tick();
        slot_t cur;
        bit hold, bub;
        cur  = {in_valid, in_we, in_addr, in_data};
        hold = stall[4] && stall[5];
        bub  = stall[4] && !stall[5];
        @(posedge clk);
        m1 = advance(m1, 1, cur, rst || flush, hold, bub);
        m3 = advance(m3, 3, cur, rst || flush, hold, bub);
        if (rst || cnt_clr) begin
            hc1 = 0; bc1 = 0; hc3 = 0; bc3 = 0;
        end else if (!flush) begin
            if (hold) begin hc1 = sat(hc1, 15); hc3 = sat(hc3, 65535); end
            if (bub)  begin bc1 = sat(bc1, 15); bc3 = sat(bc3, 65535); end
        end
        #1;
    endtask

    task automatic rand_slot();
        in_valid = 1'($urandom);
        in_we    = 3'($urandom);
        in_addr  = 15'($urandom);
        in_data  = {$urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'd0; in_valid = 1'b1; in_we = 3'b111;
        in_addr = 15'($urandom); in_data = {$urandom, $urandom, $urandom};
        repeat (2) tick();
        checks++; if (o1_s !== 115'd0) begin failures++; $display("FAIL reset_d1 got=%h exp=0", o1_s); end
        checks++; if (o3_s !== 115'd0) begin failures++; $display("FAIL reset_d3 got=%h exp=0", o3_s); end
        checks++; if ({o1_hold, o1_bub, o3_hold, o3_bub} !== 40'd0) begin
            failures++; $display("FAIL reset_cnt got=%h exp=0", {o1_hold, o1_bub, o3_hold, o3_bub}); end
        rst = 1'b0;
        tick();
        checks++; if (o1_we !== 3'b111 || o1_valid !== 1'b1) begin
            failures++; $display("FAIL first_load got_we=%b got_v=%b exp_we=111 exp_v=1", o1_we, o1_valid); end
    endtask

    task automatic test_streaming();
        stall = 6'd0; in_valid = 1'b1; in_we = 3'b001; in_addr = 15'd1;
        for (int i = 1; i <= 10; i++) begin
            in_data = {64'd0, 32'(i)};
            tick();
            if (i >= 3) begin
                checks++; if (o3_data[31:0] !== 32'(i - 2)) begin
                    failures++; $display("FAIL stream_d3 i=%0d got=%0d exp=%0d", i, o3_data[31:0], i - 2); end
            end
        end
        checks++; if (o3_hold !== 16'd0 || o3_bub !== 16'd0) begin
            failures++; $display("FAIL stream_cnt got=%0d/%0d exp=0/0", o3_hold, o3_bub); end
    endtask

    task automatic test_hold_bubble();
        slot_t saved;
        int h0, b0;
        stall = 6'd0; rand_slot(); in_valid = 1'b1;
        saved = {in_valid, in_we, in_addr, in_data};
        tick();
        h0 = hc1; b0 = bc1;
        stall = 6'b110000;
        for (int i = 0; i < 2; i++) begin
            rand_slot();
            tick();
            checks++; if (o1_s !== saved) begin failures++; $display("FAIL hold_frozen got=%h exp=%h", o1_s, saved); end
            checks++; if (o3_s !== m3[$]) begin failures++; $display("FAIL hold_d3 got=%h exp=%h", o3_s, m3[$]); end
        end
        checks++; if (o1_hold !== 4'(h0 + 2)) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", o1_hold, h0 + 2); end
        stall = 6'b010000; rand_slot();
        tick();
        checks++; if (o1_s !== 115'd0) begin failures++; $display("FAIL bubble_zero got=%h exp=0", o1_s); end
        checks++; if (o1_bub !== 4'(b0 + 1)) begin failures++; $display("FAIL bubble_cnt got=%0d exp=%0d", o1_bub, b0 + 1); end
        stall = 6'd0;
    endtask

    task automatic test_flush();
        int h3;
        stall = 6'd0;
        for (int i = 0; i < 3; i++) begin rand_slot(); in_valid = 1'b1; tick(); end
        h3 = hc3;
        flush = 1'b1; stall = 6'b110000;
        tick();
        checks++; if (o1_s !== 115'd0 || o3_s !== 115'd0) begin
            failures++; $display("FAIL flush_zero got1=%h got3=%h exp=0", o1_s, o3_s); end
        checks++; if (o3_hold !== 16'(h3)) begin failures++; $display("FAIL flush_hold got=%0d exp=%0d", o3_hold, h3); end
        flush = 1'b0; stall = 6'd0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (o3_valid !== (i == 3)) begin
                failures++; $display("FAIL flush_drain i=%0d got=%b exp=%b", i, o3_valid, (i == 3)); end
        end
    endtask

    task automatic test_saturation();
        stall = 6'b110000;
        repeat (20) tick();
        checks++; if (o1_hold !== 4'd15) begin failures++; $display("FAIL sat got=%0d exp=15", o1_hold); end
        cnt_clr = 1'b1;
        tick();
        checks++; if (o1_hold !== 4'd0) begin failures++; $display("FAIL clr got=%0d exp=0", o1_hold); end
        cnt_clr = 1'b0;
        tick();
        checks++; if (o1_hold !== 4'd1) begin failures++; $display("FAIL after_clr got=%0d exp=1", o1_hold); end
        checks++; if (o3_hold !== 16'd1) begin failures++; $display("FAIL after_clr_d3 got=%0d exp=1", o3_hold); end
        stall = 6'd0;
    endtask

    task automatic test_packing();
        stall = 6'd0; in_valid = 1'b1; in_we = 3'b010;
        in_addr = 15'd0; in_addr[5 +: 5] = 5'd31;
        in_data = 96'd0; in_data[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        checks++; if (o1_addr !== 15'h03E0 || o1_we !== 3'b010) begin
            failures++; $display("FAIL pack_addr got=%h/%b exp=03e0/010", o1_addr, o1_we); end
        checks++; if (o1_data !== {32'h0, 32'hDEAD_BEEF, 32'h0}) begin
            failures++; $display("FAIL pack_data got=%h exp=%h", o1_data, {32'h0, 32'hDEAD_BEEF, 32'h0}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_slot();
            stall   = 6'($urandom);
            flush   = ($urandom_range(15) == 0);
            rst     = ($urandom_range(63) == 0);
            cnt_clr = ($urandom_range(15) == 0);
            tick();
            checks++; if (o1_s !== m1[$] || o3_s !== m3[$]) begin
                failures++; $display("FAIL rand_slot i=%0d got1=%h exp1=%h got3=%h exp3=%h", i, o1_s, m1[$], o3_s, m3[$]); end
            checks++; if (o1_hold !== 4'(hc1) || o1_bub !== 4'(bc1) || o3_hold !== 16'(hc3) || o3_bub !== 16'(bc3)) begin
                failures++; $display("FAIL rand_cnt i=%0d got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                                     i, o1_hold, o1_bub, o3_hold, o3_bub, hc1, bc1, hc3, bc3); end
        end
        rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = 6'd0;
    endtask

    initial begin
        m1 = {'0};
        m3 = {'0, '0, '0};
        test_reset();
        test_streaming();
        test_hold_bubble();
        test_flush();
        test_saturation();
        test_packing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
